adc_channel_scheduler: RTL and testbench
========================================

// Module: adc_channel_scheduler
// PURPOSE
//  Sequences the shared 14-bit ADC across up to 8 input channels in round-robin order.
//  Drives adc_start and adc_channel_ind, then waits for adc_ready.
//  Averages 2^AVG_LOG2 conversions per channel and emits one tagged result per channel visit.
//  Sits between the ADC interface block and the per-channel result consumers (adc_current_*).
// PARAMETERS
//  NUM_CH          4    number of channels sequenced, 1..8
//  AVG_LOG2        2    log2 of conversions averaged per channel visit, 0..4
//  SETTLE_CYCLES   8    clk cycles the channel select is held before adc_start, >=1
//  TIMEOUT_CYCLES  1024 clk cycles in WAIT without adc_ready before the visit is abandoned
// PORTS
//  clk              in   1       system clock; all logic on rising edge
//  rst              in   1       synchronous reset, active-high
//  enable           in   1       1 = run the sequence continuously
//  ch_mask          in   NUM_CH  per-channel enable; bit i = channel i
//  adc_start        out  1       one-cycle conversion start pulse to the ADC
//  adc_channel_ind  out  3       channel select to the ADC mux
//  adc_ready        in   1       one-cycle pulse: conversion complete, adc_value valid
//  adc_value        in   14      unsigned conversion result
//  result_value     out  14      averaged result
//  result_ch        out  3       channel of result_value
//  result_valid     out  1       one-cycle strobe; result_value and result_ch valid
//  timeout_err      out  1       one-cycle strobe; a visit was abandoned on timeout
//  busy             out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; channel pointer 0; accumulator 0; counters 0.
//  States:
//   IDLE -> SELECT when enable=1 and ch_mask!=0.
//    - Target channel: first set mask bit at or after the pointer, wrapping modulo NUM_CH.
//    - ch_mask is sampled at this decision only.
//   SELECT: adc_channel_ind = chosen channel; hold SETTLE_CYCLES cycles -> START.
//   START: adc_start=1 for exactly this one cycle -> WAIT.
//   WAIT: count cycles; exits on the first of the following.
//    - adc_ready=1: acc += adc_value, sample count +1.
//      - Not the last sample: -> START (no re-settle).
//      - Last sample: register result, -> NEXT.
//    - Count reaches TIMEOUT_CYCLES: drop acc, timeout_err=1 for one cycle, -> NEXT.
//    - adc_ready in the same cycle as timeout expiry: ready wins, no timeout.
//   NEXT: clear acc, sample count and wait count; pointer = channel+1 mod NUM_CH.
//    - enable=1 and mask!=0: -> SELECT with the next enabled channel.
//    - Otherwise: -> IDLE.
//  adc_channel_ind is stable from SELECT entry until NEXT; it changes only in SELECT.
//  adc_ready outside WAIT is ignored.
//  Accumulator: 14+AVG_LOG2 bits unsigned; no overflow possible.
//  result_value = acc >> AVG_LOG2 (truncating); AVG_LOG2=0 passes adc_value through.
//  Result timing: result_value, result_ch and result_valid are updated at the edge that samples the final adc_ready.
//    - result_valid is high for exactly one cycle; result_value and result_ch hold until the next result.
//  enable deassert takes effect at NEXT only; an in-flight visit always completes or times out.
//  Only one conversion is outstanding at any time.
//  rst at any time, including mid-WAIT, returns everything to reset values the next cycle.
//    - No result_valid or timeout_err is generated for the aborted visit.
//  Single-channel mask: the same channel is revisited back-to-back, re-settling every visit.
// TESTING
//  1. NUM_CH=4, mask=4'b1011, AVG_LOG2=0, ADC model replies value=ch*100 after 10 cycles
//     -> results (ch,val) = (0,0),(1,100),(3,300),(0,0); channel 2 never driven.
//  2. AVG_LOG2=2, model returns 1000,1001,1002,1003 on channel 0
//     -> one result_valid, value 1001; exactly 4 adc_start pulses, no SELECT between them.
//  3. Model never asserts adc_ready, TIMEOUT_CYCLES=16
//     -> timeout_err 16 cycles after adc_start, no result_valid, next enabled channel selected.
//  4. enable=1, mask=0 -> busy stays 0, adc_start never asserted; then mask=4'b0100
//     -> SELECT on ch 2, adc_start after 8 settle cycles.
//  5. rst asserted 3 cycles into WAIT, ready pulsed 2 cycles later
//     -> all outputs 0, no result_valid; restart begins at channel 0.
//  6. AVG_LOG2=2, four samples of 16383 -> result 16383; ready on the timeout-expiry cycle
//     -> valid result, no timeout_err.

Source files
------------

// File: rtl/adc_channel_scheduler.sv
// Round-robin sequencer for a shared 14-bit ADC: settles the mux, issues conversions,
// averages 2^AVG_LOG2 samples per channel visit and emits one tagged result per visit.
module adc_channel_scheduler #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned ADC_W         = 14,
    localparam int unsigned CH_W          = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              adc_start,
    output logic [CH_W-1:0]   adc_channel_ind,
    input  logic              adc_ready,
    input  logic [ADC_W-1:0]  adc_value,
    output logic [ADC_W-1:0]  result_value,
    output logic [CH_W-1:0]   result_ch,
    output logic              result_valid,
    output logic              timeout_err,
    output logic              busy
);

    localparam int unsigned ACC_W  = ADC_W + AVG_LOG2;
    localparam int unsigned SAMP_W = AVG_LOG2 + 1;
    localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SAMP_W-1:0] LAST_SAMP   = SAMP_W'((1 << AVG_LOG2) - 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_START,
        ST_WAIT,
        ST_NEXT
    } state_t;

    state_t              state, state_d;
    logic [SET_W-1:0]    settle_cnt, settle_d;
    logic [SAMP_W-1:0]   samp_cnt, samp_d;
    logic [TMO_W-1:0]    wait_cnt, wait_d;
    logic [CH_W-1:0]     ptr, ptr_d, next_ptr;
    logic [ACC_W-1:0]    acc, acc_d, acc_sum;
    logic [CH_W-1:0]     ch_d, res_ch_d;
    logic [ADC_W-1:0]    res_val_d;
    logic                start_d, valid_d, tmo_d, busy_d;

    // First enabled channel at or after 'from', wrapping modulo NUM_CH.
    function automatic logic [CH_W-1:0] pick_ch(input logic [NUM_CH-1:0] mask,
                                                input logic [CH_W-1:0]   from);
        logic [7:0]      mask8;
        logic [CH_W-1:0] sel;
        logic            found;
        int unsigned     idx;
        mask8 = 8'(mask);
        sel   = from;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = (32'(from) + k) % NUM_CH;
            if (!found && mask8[CH_W'(idx)]) begin
                sel   = CH_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign next_ptr = CH_W'((32'(adc_channel_ind) + 32'd1) % NUM_CH);

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            settle_cnt      <= '0;
            samp_cnt        <= '0;
            wait_cnt        <= '0;
            ptr             <= '0;
            acc             <= '0;
            adc_start       <= 1'b0;
            adc_channel_ind <= '0;
            result_value    <= '0;
            result_ch       <= '0;
            result_valid    <= 1'b0;
            timeout_err     <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state           <= state_d;
            settle_cnt      <= settle_d;
            samp_cnt        <= samp_d;
            wait_cnt        <= wait_d;
            ptr             <= ptr_d;
            acc             <= acc_d;
            adc_start       <= start_d;
            adc_channel_ind <= ch_d;
            result_value    <= res_val_d;
            result_ch       <= res_ch_d;
            result_valid    <= valid_d;
            timeout_err     <= tmo_d;
            busy            <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        settle_d  = settle_cnt;
        samp_d    = samp_cnt;
        wait_d    = wait_cnt;
        ptr_d     = ptr;
        acc_d     = acc;
        acc_sum   = acc + ACC_W'(adc_value);
        ch_d      = adc_channel_ind;
        res_val_d = result_value;
        res_ch_d  = result_ch;
        start_d   = 1'b0;
        valid_d   = 1'b0;
        tmo_d     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (enable && (|ch_mask)) begin
                    state_d  = ST_SELECT;
                    ch_d     = pick_ch(ch_mask, ptr);
                    settle_d = '0;
                end
            end
            ST_SELECT: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_d = ST_START;
                    start_d = 1'b1;
                end else begin
                    settle_d = settle_cnt + 1'b1;
                end
            end
            ST_START: begin
                // Counts cycles since the start pulse; expiry is judged in WAIT.
                state_d = ST_WAIT;
                wait_d  = TMO_W'(1);
            end
            ST_WAIT: begin
                if (adc_ready) begin
                    acc_d = acc_sum;
                    if (samp_cnt == LAST_SAMP) begin
                        res_val_d = ADC_W'(acc_sum >> AVG_LOG2);
                        res_ch_d  = adc_channel_ind;
                        valid_d   = 1'b1;
                        state_d   = ST_NEXT;
                    end else begin
                        samp_d  = samp_cnt + 1'b1;
                        state_d = ST_START;
                        start_d = 1'b1;
                    end
                end else if (wait_cnt >= TMO_LAST) begin
                    acc_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = ST_NEXT;
                end else begin
                    wait_d = wait_cnt + 1'b1;
                end
            end
            ST_NEXT: begin
                acc_d  = '0;
                samp_d = '0;
                wait_d = '0;
                ptr_d  = next_ptr;
                if (enable && (|ch_mask)) begin
                    state_d  = ST_SELECT;
                    ch_d     = pick_ch(ch_mask, next_ptr);
                    settle_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Bench for adc_channel_scheduler: behavioural ADC responder plus result/event logs,
// checked per scenario against round-robin order and arithmetic averages.
module tb_adc_channel_scheduler;

    localparam int NUM_CH  = 4;
    localparam int AVG_L2  = 2;
    localparam int NAVG    = 4;
    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 16;

    typedef struct {
        int ch;
        int val;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  ch_mask;
    logic        adc_start;
    logic [2:0]  adc_channel_ind;
    logic        adc_ready;
    logic [13:0] adc_value;
    logic [13:0] result_value;
    logic [2:0]  result_ch;
    logic        result_valid;
    logic        timeout_err;
    logic        busy;

    adc_channel_scheduler #(
        .NUM_CH(NUM_CH), .AVG_LOG2(AVG_L2), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
        .adc_start(adc_start), .adc_channel_ind(adc_channel_ind),
        .adc_ready(adc_ready), .adc_value(adc_value),
        .result_value(result_value), .result_ch(result_ch), .result_valid(result_valid),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ADC responder state and expected averages it implies
    bit   model_on = 1'b0;
    bit   no_reply = 1'b0;
    int   resp_delay = 10;
    int   val_mode = 0;
    int   val_q[$];
    int   pend = 0, pend_val = 0, pend_ch = 0, samp_n = 0, samp_sum = 0;
    res_t exp_q[$];

    // Event logs
    res_t     obs_q[$];
    int       start_cyc_q[$];
    int       start_ch_q[$];
    int       tmo_cyc_q[$];
    int       busy_cnt = 0, first_busy = -1, double_start = 0;
    bit       prev_start = 1'b0;
    bit [7:0] ind_seen = '0;

    initial begin
        adc_ready = 1'b0;
        adc_value = '0;
        forever begin
            @(posedge clk);
            #1;
            if (model_on) begin
                adc_ready = 1'b0;
                if (rst) begin
                    pend = 0; samp_n = 0; samp_sum = 0;
                end else begin
                    if (pend > 0) begin
                        pend--;
                        if (pend == 0) begin
                            adc_ready = 1'b1;
                            adc_value = 14'(pend_val);
                            samp_sum += pend_val;
                            samp_n++;
                            if (samp_n == NAVG) begin
                                exp_q.push_back('{pend_ch, samp_sum / NAVG});
                                samp_n = 0; samp_sum = 0;
                            end
                        end
                    end
                    if (adc_start) begin
                        pend_ch = int'(adc_channel_ind);
                        if (no_reply) begin
                            samp_n = 0; samp_sum = 0;
                        end else begin
                            pend = (resp_delay == 0) ? int'($urandom_range(15, 1)) : resp_delay;
                            if (val_mode == 0) pend_val = pend_ch * 100;
                            else if (val_mode == 1) pend_val = (val_q.size() > 0) ? val_q.pop_front() : 0;
                            else pend_val = int'($urandom_range(16383, 0));
                        end
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (result_valid) obs_q.push_back('{int'(result_ch), int'(result_value)});
        if (adc_start) begin
            start_cyc_q.push_back(cyc);
            start_ch_q.push_back(int'(adc_channel_ind));
            if (prev_start) double_start++;
        end
        prev_start = adc_start;
        if (timeout_err) tmo_cyc_q.push_back(cyc);
        if (busy) begin
            busy_cnt++;
            ind_seen[adc_channel_ind] = 1'b1;
            if (first_busy < 0) first_busy = cyc;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        obs_q.delete(); start_cyc_q.delete(); start_ch_q.delete(); tmo_cyc_q.delete();
        exp_q.delete(); val_q.delete();
        busy_cnt = 0; first_busy = -1; double_start = 0; ind_seen = '0;
        samp_n = 0; samp_sum = 0;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1; enable = 1'b0; ch_mask = '0;
        step();
        step();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_results(input int n, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (obs_q.size() >= n) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic wait_starts(input int n, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (start_cyc_q.size() >= n) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (busy === 1'b0) begin ok = 1'b1; break; end
            step();
        end
    endtask

    // Channel visited after pointer p under the round-robin rule
    function automatic int rr_pick(input logic [3:0] m, input int p);
        for (int k = 0; k < NUM_CH; k++)
            if (((m >> ((p + k) % NUM_CH)) & 4'd1) != 4'd0) return (p + k) % NUM_CH;
        return -1;
    endfunction

    task automatic enable_pulse();
        enable = 1'b1;
        step();
        enable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; ch_mask = 4'hF;
        step(); step(); step();
        n_chk++; if (adc_start !== 1'b0) $display("FAIL reset_adc_start: got %b want 0", adc_start); else n_pass++;
        n_chk++; if (adc_channel_ind !== 3'd0) $display("FAIL reset_ch_ind: got %0d want 0", adc_channel_ind); else n_pass++;
        n_chk++; if (result_value !== 14'd0) $display("FAIL reset_result_value: got %0d want 0", result_value); else n_pass++;
        n_chk++; if (result_ch !== 3'd0) $display("FAIL reset_result_ch: got %0d want 0", result_ch); else n_pass++;
        n_chk++; if (result_valid !== 1'b0) $display("FAIL reset_result_valid: got %b want 0", result_valid); else n_pass++;
        n_chk++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", timeout_err); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        rst = 1'b0; enable = 1'b0; ch_mask = '0;
        clear_logs();
    endtask

    task automatic test_round_robin();
        bit ok;
        int p, c;
        do_reset();
        model_on = 1'b1; no_reply = 1'b0; resp_delay = 10; val_mode = 0;
        ch_mask = 4'b1011; enable = 1'b1;
        wait_results(4, 1500, ok);
        enable = 1'b0;
        n_chk++; if (!ok) $display("FAIL rr_result_wait: got %0d results want 4", obs_q.size()); else n_pass++;
        wait_idle(500, ok);
        n_chk++; if (!ok) $display("FAIL rr_idle_wait: busy=%b want 0", busy); else n_pass++;
        p = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            c = rr_pick(4'b1011, p);
            p = (c + 1) % NUM_CH;
            n_chk++; if (obs_q[i].ch != c) $display("FAIL rr_ch[%0d]: got %0d want %0d", i, obs_q[i].ch, c); else n_pass++;
            n_chk++; if (obs_q[i].val != c * 100) $display("FAIL rr_val[%0d]: got %0d want %0d", i, obs_q[i].val, c * 100); else n_pass++;
        end
        n_chk++; if (ind_seen[2] !== 1'b0) $display("FAIL rr_ch2_driven: got %b want 0", ind_seen[2]); else n_pass++;
        n_chk++; if (start_cyc_q.size() != NAVG * obs_q.size())
            $display("FAIL rr_start_count: got %0d want %0d", start_cyc_q.size(), NAVG * obs_q.size()); else n_pass++;
    endtask

    task automatic test_averaging();
        bit ok;
        do_reset();
        model_on = 1'b1; no_reply = 1'b0; resp_delay = 10; val_mode = 1;
        val_q = '{1000, 1001, 1002, 1003};
        ch_mask = 4'b0001;
        enable_pulse();
        wait_idle(500, ok);
        n_chk++; if (!ok) $display("FAIL avg_idle_wait: busy=%b want 0", busy); else n_pass++;
        n_chk++; if (obs_q.size() != 1) $display("FAIL avg_result_count: got %0d want 1", obs_q.size()); else n_pass++;
        if (obs_q.size() >= 1) begin
            n_chk++; if (obs_q[0].val != 1001) $display("FAIL avg_value: got %0d want 1001", obs_q[0].val); else n_pass++;
            n_chk++; if (obs_q[0].ch != 0) $display("FAIL avg_ch: got %0d want 0", obs_q[0].ch); else n_pass++;
        end
        n_chk++; if (start_cyc_q.size() != 4) $display("FAIL avg_start_count: got %0d want 4", start_cyc_q.size()); else n_pass++;
        for (int i = 1; i < start_cyc_q.size(); i++) begin
            n_chk++; if (start_cyc_q[i] - start_cyc_q[i-1] != 11)
                $display("FAIL avg_no_resettle[%0d]: got gap %0d want 11", i, start_cyc_q[i] - start_cyc_q[i-1]); else n_pass++;
        end
        n_chk++; if (double_start != 0) $display("FAIL avg_start_width: got %0d long pulses want 0", double_start); else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        model_on = 1'b1; no_reply = 1'b1;
        ch_mask = 4'b0011; enable = 1'b1;
        wait_starts(2, 500, ok);
        enable = 1'b0;
        n_chk++; if (!ok) $display("FAIL tmo_start_wait: got %0d starts want 2", start_cyc_q.size()); else n_pass++;
        wait_idle(500, ok);
        n_chk++; if (!ok) $display("FAIL tmo_idle_wait: busy=%b want 0", busy); else n_pass++;
        n_chk++; if (tmo_cyc_q.size() != 2) $display("FAIL tmo_count: got %0d want 2", tmo_cyc_q.size()); else n_pass++;
        if (tmo_cyc_q.size() >= 1 && start_cyc_q.size() >= 1) begin
            n_chk++; if (tmo_cyc_q[0] - start_cyc_q[0] != TIMEOUT)
                $display("FAIL tmo_latency: got %0d want %0d", tmo_cyc_q[0] - start_cyc_q[0], TIMEOUT); else n_pass++;
        end
        if (start_ch_q.size() >= 2) begin
            n_chk++; if (start_ch_q[1] != 1) $display("FAIL tmo_next_ch: got %0d want 1", start_ch_q[1]); else n_pass++;
        end
        n_chk++; if (obs_q.size() != 0) $display("FAIL tmo_no_result: got %0d results want 0", obs_q.size()); else n_pass++;
        no_reply = 1'b0;
    endtask

    task automatic test_idle_mask();
        bit ok;
        do_reset();
        model_on = 1'b1; resp_delay = 5; val_mode = 0;
        enable = 1'b1; ch_mask = 4'b0000;
        repeat (30) step();
        n_chk++; if (busy_cnt != 0) $display("FAIL mask0_busy: got %0d busy cycles want 0", busy_cnt); else n_pass++;
        n_chk++; if (start_cyc_q.size() != 0) $display("FAIL mask0_start: got %0d starts want 0", start_cyc_q.size()); else n_pass++;
        ch_mask = 4'b0100;
        wait_starts(1, 100, ok);
        enable = 1'b0;
        n_chk++; if (!ok) $display("FAIL mask4_start_wait: got %0d starts want 1", start_cyc_q.size()); else n_pass++;
        if (ok) begin
            n_chk++; if (start_ch_q[0] != 2) $display("FAIL mask4_ch: got %0d want 2", start_ch_q[0]); else n_pass++;
            n_chk++; if (start_cyc_q[0] - first_busy != SETTLE)
                $display("FAIL mask4_settle: got %0d want %0d", start_cyc_q[0] - first_busy, SETTLE); else n_pass++;
        end
        wait_idle(500, ok);
        n_chk++; if (ind_seen != 8'b0000_0100) $display("FAIL mask4_ind_seen: got %b want 00000100", ind_seen); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        do_reset();
        model_on = 1'b1; resp_delay = 4; val_mode = 2;
        ch_mask = 4'b0100; enable = 1'b1;
        wait_results(1, 500, ok);
        model_on = 1'b0; adc_ready = 1'b0;
        start_cyc_q.delete(); start_ch_q.delete();
        wait_starts(1, 100, ok);
        n_chk++; if (!ok) $display("FAIL rstw_start_wait: got %0d starts want 1", start_cyc_q.size()); else n_pass++;
        ch_mask = 4'b1111;
        step(); step(); step();
        rst = 1'b1;
        step();
        n_chk++; if (adc_start !== 1'b0) $display("FAIL rstw_adc_start: got %b want 0", adc_start); else n_pass++;
        n_chk++; if (adc_channel_ind !== 3'd0) $display("FAIL rstw_ch_ind: got %0d want 0", adc_channel_ind); else n_pass++;
        n_chk++; if (result_value !== 14'd0) $display("FAIL rstw_result_value: got %0d want 0", result_value); else n_pass++;
        n_chk++; if (result_ch !== 3'd0) $display("FAIL rstw_result_ch: got %0d want 0", result_ch); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rstw_busy: got %b want 0", busy); else n_pass++;
        rst = 1'b0;
        clear_logs();
        adc_ready = 1'b1; adc_value = 14'd777;
        step();
        adc_ready = 1'b0;
        model_on = 1'b1; resp_delay = 6; val_mode = 0;
        wait_starts(1, 100, ok);
        enable = 1'b0;
        n_chk++; if (!ok || start_ch_q[0] != 0)
            $display("FAIL rstw_restart_ch: got %0d want 0", ok ? start_ch_q[0] : -1); else n_pass++;
        wait_idle(500, ok);
        n_chk++; if (obs_q.size() != 1) $display("FAIL rstw_result_count: got %0d want 1", obs_q.size()); else n_pass++;
        if (obs_q.size() >= 1) begin
            n_chk++; if (obs_q[0].ch != 0 || obs_q[0].val != 0)
                $display("FAIL rstw_result: got ch %0d val %0d want ch 0 val 0", obs_q[0].ch, obs_q[0].val); else n_pass++;
        end
        n_chk++; if (tmo_cyc_q.size() != 0) $display("FAIL rstw_no_timeout: got %0d want 0", tmo_cyc_q.size()); else n_pass++;
    endtask

    task automatic test_full_scale();
        bit ok;
        do_reset();
        model_on = 1'b1; resp_delay = TIMEOUT - 1; val_mode = 1;
        val_q = '{16383, 16383, 16383, 16383};
        ch_mask = 4'b0001;
        enable_pulse();
        wait_idle(500, ok);
        n_chk++; if (obs_q.size() != 1 || obs_q[0].val != 16383)
            $display("FAIL fs_value: got %0d results, val %0d want 1 result val 16383",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0].val : -1); else n_pass++;
        n_chk++; if (tmo_cyc_q.size() != 0) $display("FAIL fs_edge_ready_timeout: got %0d want 0", tmo_cyc_q.size()); else n_pass++;
        clear_logs();
        resp_delay = TIMEOUT;
        val_q = '{5000};
        enable_pulse();
        wait_idle(500, ok);
        n_chk++; if (tmo_cyc_q.size() != 1) $display("FAIL fs_late_timeout: got %0d want 1", tmo_cyc_q.size()); else n_pass++;
        n_chk++; if (obs_q.size() != 0) $display("FAIL fs_late_result: got %0d want 0", obs_q.size()); else n_pass++;
    endtask

    task automatic test_random();
        bit ok;
        int p, c;
        logic [3:0] m;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            m = 4'($urandom_range(15, 1));
            model_on = 1'b1; no_reply = 1'b0; resp_delay = 0; val_mode = 2;
            ch_mask = m; enable = 1'b1;
            wait_results(5, 3000, ok);
            enable = 1'b0;
            n_chk++; if (!ok) $display("FAIL rnd%0d_wait: got %0d results want 5", r, obs_q.size()); else n_pass++;
            wait_idle(500, ok);
            n_chk++; if (obs_q.size() != exp_q.size())
                $display("FAIL rnd%0d_count: got %0d want %0d", r, obs_q.size(), exp_q.size()); else n_pass++;
            p = 0;
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                c = rr_pick(m, p);
                p = (c + 1) % NUM_CH;
                n_chk++; if (obs_q[i].ch != c || obs_q[i].val != exp_q[i].val)
                    $display("FAIL rnd%0d_res[%0d]: got ch %0d val %0d want ch %0d val %0d",
                             r, i, obs_q[i].ch, obs_q[i].val, c, exp_q[i].val); else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; ch_mask = '0;
        test_reset();
        test_round_robin();
        test_averaging();
        test_timeout();
        test_idle_mask();
        test_reset_mid_wait();
        test_full_scale();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
